pmem_arbiter: RTL

//  Sits directly downstream of the i-cache and d-cache physical-memory ports.

---
 rtl/arb_pkg.sv | 8 +
 rtl/arb_req_latch.sv | 40 ++++
 rtl/pmem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the physical-memory arbiter
package arb_pkg;
  localparam int DEF_S_OFFSET = 5;
  localparam int DEF_S_LINE   = 8 * (2 ** DEF_S_OFFSET);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, COOL} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} client_t;
endpackage

// File: rtl/arb_req_latch.sv
// rtl/arb_req_latch.sv - per-transaction line address / wdata / op register
module arb_req_latch #(
  parameter int S_OFFSET = 5,
  parameter int S_LINE   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 ld_write,
  input  logic [31-S_OFFSET:0] ld_line,
  input  logic [S_LINE-1:0]    ld_wdata,
  output logic                 valid,
  output logic                 write,
  output logic [31:0]          addr,
  output logic [S_LINE-1:0]    wdata
);
  logic [31-S_OFFSET:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      write  <= 1'b0;
      line_q <= '0;
      wdata  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      write  <= ld_write;
      line_q <= ld_line;
      wdata  <= ld_write ? ld_wdata : '0;
    end else if (clear) begin
      valid  <= 1'b0;
      write  <= 1'b0;
      line_q <= '0;
      wdata  <= '0;
    end
  end

  assign addr = {line_q, {S_OFFSET{1'b0}}};
endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin i-cache/d-cache arbiter onto one line memory port
// Optional performance counters: ARB_PERF_COUNTERS_EN
import arb_pkg::*;

module pmem_arbiter #(
  parameter int S_OFFSET = DEF_S_OFFSET,
  parameter int S_LINE   = 8 * (2 ** S_OFFSET)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ARB_PERF_COUNTERS_EN
  input  logic              arb_count_reset,
  output logic [31:0]       arb_conflict_count,
  output logic [31:0]       arb_wait_count,
`endif
  input  logic              icache_pmem_read,
  input  logic              icache_pmem_write,
  input  logic [31:0]       icache_pmem_addr,
  input  logic [S_LINE-1:0] icache_pmem_wdata,
  output logic [S_LINE-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [31:0]       dcache_pmem_addr,
  input  logic [S_LINE-1:0] dcache_pmem_wdata,
  output logic [S_LINE-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [S_LINE-1:0] mem_wdata,
  input  logic [S_LINE-1:0] mem_rdata,
  input  logic              mem_resp
);
  arb_state_t state, state_nx;
  client_t    last_grant, last_grant_nx;

  logic pend_i, pend_d, cool_i, cool_d;
  logic gnt_i, gnt_d, clear;
  logic lat_valid, lat_write;
  logic [S_LINE-1:0] rdata_i_q, rdata_d_q;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{icache_pmem_addr[S_OFFSET-1:0], dcache_pmem_addr[S_OFFSET-1:0]};

  // In COOL last_grant still names the client just served; its request is stale for one edge.
  assign cool_i = (state == COOL) && (last_grant == ICACHE);
  assign cool_d = (state == COOL) && (last_grant == DCACHE);
  assign pend_i = (icache_pmem_read | icache_pmem_write) & ~cool_i;
  assign pend_d = (dcache_pmem_read | dcache_pmem_write) & ~cool_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= DCACHE;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    gnt_i         = 1'b0;
    gnt_d         = 1'b0;
    clear         = 1'b0;
    case (state)
      IDLE: begin
        if (pend_i && (!pend_d || last_grant == DCACHE)) begin
          gnt_i         = 1'b1;
          state_nx      = BUSY_I;
          last_grant_nx = ICACHE;
        end else if (pend_d) begin
          gnt_d         = 1'b1;
          state_nx      = BUSY_D;
          last_grant_nx = DCACHE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          clear    = 1'b1;
          state_nx = COOL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  arb_req_latch #(.S_OFFSET(S_OFFSET), .S_LINE(S_LINE)) u_req_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gnt_i | gnt_d),
    .clear    (clear),
    .ld_write (gnt_i ? icache_pmem_write : dcache_pmem_write),
    .ld_line  (gnt_i ? icache_pmem_addr[31:S_OFFSET] : dcache_pmem_addr[31:S_OFFSET]),
    .ld_wdata (gnt_i ? icache_pmem_wdata : dcache_pmem_wdata),
    .valid    (lat_valid),
    .write    (lat_write),
    .addr     (mem_addr),
    .wdata    (mem_wdata)
  );

  assign mem_read  = lat_valid & ~lat_write;
  assign mem_write = lat_valid & lat_write;

  assign icache_pmem_resp = (state == BUSY_I) && mem_resp;
  assign dcache_pmem_resp = (state == BUSY_D) && mem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_i_q <= '0;
      rdata_d_q <= '0;
    end else begin
      if (icache_pmem_resp) rdata_i_q <= mem_rdata;
      if (dcache_pmem_resp) rdata_d_q <= mem_rdata;
    end
  end

  assign icache_pmem_rdata = icache_pmem_resp ? mem_rdata : rdata_i_q;
  assign dcache_pmem_rdata = dcache_pmem_resp ? mem_rdata : rdata_d_q;

`ifdef ARB_PERF_COUNTERS_EN
  logic wait_any;
  assign wait_any = (pend_i & ~(gnt_i | (state == BUSY_I))) |
                    (pend_d & ~(gnt_d | (state == BUSY_D)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_conflict_count <= '0;
      arb_wait_count     <= '0;
    end else if (arb_count_reset) begin
      arb_conflict_count <= '0;
      arb_wait_count     <= '0;
    end else begin
      if (state == IDLE && pend_i && pend_d) arb_conflict_count <= arb_conflict_count + 32'd1;
      if (wait_any) arb_wait_count <= arb_wait_count + 32'd1;
    end
  end
`endif
endmodule
